// File: rtl/port_window_decoder.sv
// I/O port window decoder: per-channel base/mask/wait windows, configured through four ports at CFG_BASE.
// Optional configuration readback is compiled in with the PORTDEC_READBACK_EN macro.
module port_window_decoder #(
  parameter int          NUM_CH   = 8,
  parameter logic [7:0]  CFG_BASE = 8'hF8,
  parameter int          WAIT_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        address,
  input  logic [7:0]        data_in,
  input  logic              iowrite,
  input  logic              ioread,
  output logic [NUM_CH-1:0] cs,
  output logic              cs_write,
  output logic              cs_read,
  output logic              rdy,
  output logic [7:0]        cfg_dout,
  output logic              cfg_dout_valid,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_MISS   = 3'd3,
    ST_CFG    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                strobe, strobe_q, edge_ok;
  logic [NUM_CH-1:0]   cs_q, cs_d;
  logic                cs_write_q, cs_write_d, cs_read_q, cs_read_d;
  logic                rdy_q, rdy_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]          sel_q;
  logic [7:0]          base_q [NUM_CH];
  logic [7:0]          mask_q [NUM_CH];
  logic [WAIT_W-1:0]   wait_q [NUM_CH];
  logic [NUM_CH-1:0]   en_q;

  logic [7:0]          cfg_off;
  logic                cfg_hit, cfg_wr;
  logic                hit;
  logic [NUM_CH-1:0]   hit_cs;
  logic [WAIT_W-1:0]   hit_wait;

  // A bus cycle starts on a rising strobe; a cycle with both strobes high is not a valid cycle.
  assign strobe  = ioread | iowrite;
  assign edge_ok = strobe & ~strobe_q & ~(ioread & iowrite);

  assign cfg_off = address - CFG_BASE;
  assign cfg_hit = (cfg_off < 8'd4);
  assign cfg_wr  = (state_q == ST_IDLE) && edge_ok && cfg_hit && iowrite;

  // Descending scan so the lowest matching channel overwrites the others.
  always_comb begin
    hit      = 1'b0;
    hit_cs   = '0;
    hit_wait = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (en_q[n] && ((address & mask_q[n]) == (base_q[n] & mask_q[n]))) begin
        hit       = 1'b1;
        hit_cs    = '0;
        hit_cs[n] = 1'b1;
        hit_wait  = wait_q[n];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    cs_write_d = cs_write_q;
    cs_read_d  = cs_read_q;
    rdy_d      = rdy_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_ok) begin
          if (cfg_hit) begin
            state_d = ST_CFG;
          end else if (hit) begin
            cs_d       = hit_cs;
            cs_write_d = iowrite;
            cs_read_d  = ioread;
            if (hit_wait != '0) begin
              state_d = ST_WAIT;
              cnt_d   = hit_wait;
              rdy_d   = 1'b0;
            end else begin
              state_d = ST_ACTIVE;
            end
          end else begin
            state_d = ST_MISS;
          end
        end
      end
      ST_WAIT: begin
        if (!strobe) begin
          state_d    = ST_IDLE;
          cs_d       = '0;
          cs_write_d = 1'b0;
          cs_read_d  = 1'b0;
          rdy_d      = 1'b1;
        end else if (cnt_q == WAIT_W'(1)) begin
          state_d = ST_ACTIVE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ST_ACTIVE, ST_MISS, ST_CFG: begin
        if (!strobe) begin
          state_d    = ST_IDLE;
          cs_d       = '0;
          cs_write_d = 1'b0;
          cs_read_d  = 1'b0;
          rdy_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // strobe_q follows strobe during reset so a strobe held across reset is not a new edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      strobe_q   <= strobe;
      cs_q       <= '0;
      cs_write_q <= 1'b0;
      cs_read_q  <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      strobe_q   <= strobe;
      cs_q       <= cs_d;
      cs_write_q <= cs_write_d;
      cs_read_q  <= cs_read_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  // Out-of-range selects match no channel, so those writes fall away.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel_q <= 4'd0;
      en_q  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        base_q[n] <= 8'h00;
        mask_q[n] <= 8'hFF;
        wait_q[n] <= '0;
      end
    end else if (cfg_wr) begin
      if (cfg_off[1:0] == 2'd0) sel_q <= data_in[3:0];
      for (int n = 0; n < NUM_CH; n++) begin
        if (sel_q == 4'(n)) begin
          case (cfg_off[1:0])
            2'd1: base_q[n] <= data_in;
            2'd2: mask_q[n] <= data_in;
            2'd3: begin
              en_q[n]   <= data_in[7];
              wait_q[n] <= data_in[WAIT_W-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

`ifdef PORTDEC_READBACK_EN
  logic [7:0] rb_val;
  logic [7:0] cfg_dout_q;
  logic       cfg_dout_valid_q;
  logic       cfg_rd;

  assign cfg_rd = (state_q == ST_IDLE) && edge_ok && cfg_hit && ioread;

  always_comb begin
    rb_val = 8'h00;
    if (cfg_off[1:0] == 2'd0) begin
      rb_val = {4'd0, sel_q};
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (sel_q == 4'(n)) begin
          case (cfg_off[1:0])
            2'd1: rb_val = base_q[n];
            2'd2: rb_val = mask_q[n];
            default: begin
              rb_val[7]          = en_q[n];
              rb_val[WAIT_W-1:0] = wait_q[n];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cfg_dout_q       <= 8'h00;
      cfg_dout_valid_q <= 1'b0;
    end else if (cfg_rd) begin
      cfg_dout_q       <= rb_val;
      cfg_dout_valid_q <= 1'b1;
    end else if ((state_q == ST_CFG) && !strobe) begin
      cfg_dout_valid_q <= 1'b0;
    end
  end

  assign cfg_dout       = cfg_dout_q;
  assign cfg_dout_valid = cfg_dout_valid_q;
`else
  assign cfg_dout       = 8'h00;
  assign cfg_dout_valid = 1'b0;
`endif

  assign cs        = cs_q;
  assign cs_write  = cs_write_q;
  assign cs_read   = cs_read_q;
  assign rdy       = rdy_q;
  assign fsm_state = state_q;

endmodule
